audio_lpf_decim: RTL

Real-valued low-pass FIR with integrated decimation, placed directly downstream of the FM demodulator. It reads the demodulated 32-bit fixed-point samples from the demodulator's output FIFO and keeps a tap history. After each group of DECIM new samples it computes one filtered output and writes it to the audio output FIFO. It is the first stage of the mono audio path.

---
 rtl/audio_lpf_decim_pkg.sv | 30 +++
 rtl/audio_lpf_decim_if.sv | 22 ++
 rtl/audio_lpf_decim_fir_mac.sv | 18 +
 rtl/audio_lpf_decim.sv | 112 +++++++++++
 4 files changed

// File: rtl/audio_lpf_decim_pkg.sv
// Shared constants, state encoding, coefficient set and dequantize helper
// for the decimating audio low-pass FIR.
package audio_lpf_decim_pkg;

  localparam int TAPS       = 32;
  localparam int DECIM      = 8;
  localparam int WIDTH      = 32;
  localparam int QUANT_BITS = 10;
  localparam int CNT_W      = $clog2(DECIM);
  localparam int K_W        = $clog2(TAPS);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Q10 symmetric low-pass taps (1.0 == 1024)
  localparam logic signed [WIDTH-1:0] AUDIO_LPF_COEFFS [0:TAPS-1] = '{
    -32'sd3,   -32'sd5,   -32'sd6,   -32'sd4,   32'sd2,    32'sd12,   32'sd26,   32'sd42,
    32'sd60,   32'sd78,   32'sd94,   32'sd107,  32'sd116,  32'sd121,  32'sd124,  32'sd125,
    32'sd125,  32'sd124,  32'sd121,  32'sd116,  32'sd107,  32'sd94,   32'sd78,   32'sd60,
    32'sd42,   32'sd26,   32'sd12,   32'sd2,    -32'sd4,   -32'sd6,   -32'sd5,   -32'sd3
  };

  function automatic logic signed [WIDTH-1:0] dequantize(input logic signed [WIDTH-1:0] p);
    return p >>> QUANT_BITS;
  endfunction

endpackage

// File: rtl/audio_lpf_decim_if.sv
// Upstream FIFO read port and downstream FIFO write port of the audio LPF.
interface audio_lpf_decim_if;
  import audio_lpf_decim_pkg::*;

  logic                    in_empty;
  logic                    in_rd_en;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_out;
  logic                    out_wr_en;
  logic                    out_full;

  modport master (
    output in_empty, x_in, out_full,
    input  in_rd_en, y_out, out_wr_en
  );

  modport slave (
    input  in_empty, x_in, out_full,
    output in_rd_en, y_out, out_wr_en
  );

endinterface

// File: rtl/audio_lpf_decim_fir_mac.sv
// One FIR tap term: signed multiply, keep the low WIDTH bits, dequantize.
module audio_lpf_decim_fir_mac
  import audio_lpf_decim_pkg::*;
(
  input  logic signed [WIDTH-1:0] coef,
  input  logic signed [WIDTH-1:0] sample,
  output logic signed [WIDTH-1:0] term
);

  logic signed [2*WIDTH-1:0] prod_s;

  // Full-width product; only the low half feeds the accumulator
  always_comb begin
    prod_s = (2*WIDTH)'(coef) * (2*WIDTH)'(sample);
    term   = dequantize(prod_s[WIDTH-1:0]);
  end

endmodule

// File: rtl/audio_lpf_decim.sv
// Decimating low-pass FIR: loads DECIM samples, runs TAPS MAC cycles,
// then writes one output sample downstream.
module audio_lpf_decim
  import audio_lpf_decim_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  audio_lpf_decim_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(TAPS - 1);

  state_t                  state_r, state_n;
  logic [CNT_W-1:0]        cnt_r, cnt_n;
  logic [K_W-1:0]          k_r, k_n;
  logic signed [WIDTH-1:0] acc_r, acc_n;
  logic signed [WIDTH-1:0] y_r, y_n;
  logic signed [WIDTH-1:0] hist_r [TAPS];
  logic signed [WIDTH-1:0] hist_n [TAPS];
  logic signed [WIDTH-1:0] term_s;
  logic                    rd_s;
  logic                    wr_s;

  audio_lpf_decim_fir_mac u_fir_mac (
    .coef   (AUDIO_LPF_COEFFS[k_r]),
    .sample (hist_r[k_r]),
    .term   (term_s)
  );

  // Next-state and handshake decode
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    k_n     = k_r;
    acc_n   = acc_r;
    y_n     = y_r;
    hist_n  = hist_r;
    rd_s    = 1'b0;
    wr_s    = 1'b0;
    case (state_r)
      LOAD: begin
        if (!bus.in_empty) begin
          rd_s      = 1'b1;
          hist_n[0] = bus.x_in;
          for (int i = 1; i < TAPS; i++) begin
            hist_n[i] = hist_r[i-1];
          end
          cnt_n = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_LAST) begin
            acc_n   = '0;
            k_n     = '0;
            state_n = MAC;
          end else begin
            state_n = LOAD;
          end
        end else begin
          state_n = LOAD;
        end
      end
      MAC: begin
        acc_n = acc_r + term_s;
        if (k_r == K_LAST) begin
          y_n     = acc_r + term_s;
          state_n = WRITE;
        end else begin
          k_n = k_r + {{(K_W-1){1'b0}}, 1'b1};
        end
      end
      WRITE: begin
        if (!bus.out_full) begin
          wr_s    = 1'b1;
          cnt_n   = '0;
          state_n = LOAD;
        end else begin
          state_n = WRITE;
        end
      end
      default: begin
        state_n = LOAD;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counters, accumulator, output and tap history registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= LOAD;
      cnt_r   <= '0;
      k_r     <= '0;
      acc_r   <= '0;
      y_r     <= '0;
      for (int i = 0; i < TAPS; i++) begin
        hist_r[i] <= '0;
      end
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      k_r     <= k_n;
      acc_r   <= acc_n;
      y_r     <= y_n;
      hist_r  <= hist_n;
    end
  end

  // Strobes are forced low while reset is held so nothing pops or pushes
  assign bus.in_rd_en  = rd_s & reset;
  assign bus.out_wr_en = wr_s & reset;
  assign bus.y_out     = y_r;

endmodule
